// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - CSR numbers, exception codes, field layout and write helpers
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_SAVE0     = 14'h030;
  localparam logic [13:0] CSR_SAVE1     = 14'h031;
  localparam logic [13:0] CSR_SAVE2     = 14'h032;
  localparam logic [13:0] CSR_SAVE3     = 14'h033;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam int CRMD_PLV = 0;
  localparam int CRMD_IE  = 2;
  localparam int CRMD_DA  = 3;
  localparam int CRMD_PG  = 4;
  localparam int PRMD_PPLV = 0;
  localparam int PRMD_PIE  = 2;
  localparam int ESTAT_TI  = 11;
  localparam int ESTAT_IPI = 12;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  localparam logic [31:0] CRMD_RESET  = 32'h0000_0008;
  localparam logic [31:0] CRMD_WMASK  = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK  = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK  = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK = 32'h0000_0003;
  localparam logic [31:0] ENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_WMASK  = 32'hFFFF_FFFF;

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wval,
                                         input logic [31:0] wmask, input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old & ~m) | (wval & m);
  endfunction

  function automatic logic ecode_sets_badv(input logic [5:0] ecode);
    case (ecode)
      ECODE_ADE, ECODE_ALE, ECODE_TLBR, ECODE_PIL,
      ECODE_PIS, ECODE_PIF, ECODE_PME, ECODE_PPI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_regfile_timer.sv
// rtl/csr_regfile_timer.sv - stable timer: TVAL countdown, run flag and expiry pulse
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic        tcfg_en,
  input  logic        tcfg_periodic,
  input  logic [29:0] tcfg_initval,
  output logic [31:0] tval,
  output logic        expire
);

  logic [31:0] tval_q, tval_d;
  logic        run_q, run_d;

  // A TCFG write in the expiry cycle reprograms the timer and suppresses the expiry.
  always_comb begin
    tval_d = tval_q;
    run_d  = run_q;
    expire = run_q && (tval_q == 32'h0) && !tcfg_we;
    if (tcfg_we) begin
      run_d = tcfg_en;
      if (tcfg_en) tval_d = {tcfg_initval, 2'b00};
    end else if (expire) begin
      run_d  = tcfg_periodic;
      tval_d = tcfg_periodic ? {tcfg_initval, 2'b00} : 32'hFFFF_FFFF;
    end else if (run_q) begin
      tval_d = tval_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tval_q <= 32'h0;
      run_q  <= 1'b0;
    end else begin
      tval_q <= tval_d;
      run_q  <= run_d;
    end
  end

  assign tval = tval_q;

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - WB-stage CSR file: read mux, masked writes, exception/ertn commit, interrupts
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  input  logic        current_exc_fetch,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tlbrentry_q, tlbrentry_d;
  logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d;
  logic [3:0][31:0] save_q, save_d;
  logic [31:0] tval;
  logic        csr_wr, tcfg_we, ticlr_clr, timer_expire;
  logic        unused_csr_re;

  assign unused_csr_re = csr_re;
  assign csr_wr    = csr_we && !wb_ex && !ertn_flush;
  assign tcfg_we   = csr_wr && (csr_num == CSR_TCFG);
  assign ticlr_clr = csr_wr && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];

  always_comb begin
    crmd_d = crmd_q; prmd_d = prmd_q; ecfg_d = ecfg_q; estat_d = estat_q;
    era_d = era_q; badv_d = badv_q; eentry_d = eentry_q; tlbrentry_d = tlbrentry_q;
    tid_d = tid_q; tcfg_d = tcfg_q; save_d = save_q;
    if (wb_ex) begin
      prmd_d[PRMD_PPLV +: 2] = crmd_q[CRMD_PLV +: 2];
      prmd_d[PRMD_PIE]       = crmd_q[CRMD_IE];
      crmd_d[CRMD_PLV +: 2]  = 2'b00;
      crmd_d[CRMD_IE]        = 1'b0;
      era_d                  = wb_pc;
      estat_d[21:16]         = wb_ecode;
      estat_d[30:22]         = wb_esubcode;
      if (wb_ecode == ECODE_TLBR) begin
        crmd_d[CRMD_DA] = 1'b1;
        crmd_d[CRMD_PG] = 1'b0;
      end
      if (ecode_sets_badv(wb_ecode)) badv_d = current_exc_fetch ? wb_pc : wb_vaddr;
    end else if (ertn_flush) begin
      crmd_d[CRMD_PLV +: 2] = prmd_q[PRMD_PPLV +: 2];
      crmd_d[CRMD_IE]       = prmd_q[PRMD_PIE];
      if (estat_q[21:16] == ECODE_TLBR) begin
        crmd_d[CRMD_DA] = 1'b0;
        crmd_d[CRMD_PG] = 1'b1;
      end
    end else if (csr_we) begin
      case (csr_num)
        CSR_CRMD:      crmd_d      = wmerge(crmd_q, csr_wvalue, csr_wmask, CRMD_WMASK);
        CSR_PRMD:      prmd_d      = wmerge(prmd_q, csr_wvalue, csr_wmask, PRMD_WMASK);
        CSR_ECFG:      ecfg_d      = wmerge(ecfg_q, csr_wvalue, csr_wmask, ECFG_WMASK);
        CSR_ESTAT:     estat_d     = wmerge(estat_q, csr_wvalue, csr_wmask, ESTAT_WMASK);
        CSR_ERA:       era_d       = wmerge(era_q, csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_BADV:      badv_d      = wmerge(badv_q, csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_EENTRY:    eentry_d    = wmerge(eentry_q, csr_wvalue, csr_wmask, ENTRY_WMASK);
        CSR_TLBRENTRY: tlbrentry_d = wmerge(tlbrentry_q, csr_wvalue, csr_wmask, ENTRY_WMASK);
        CSR_SAVE0:     save_d[0]   = wmerge(save_q[0], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_SAVE1:     save_d[1]   = wmerge(save_q[1], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_SAVE2:     save_d[2]   = wmerge(save_q[2], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_SAVE3:     save_d[3]   = wmerge(save_q[3], csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_TID:       tid_d       = wmerge(tid_q, csr_wvalue, csr_wmask, FULL_WMASK);
        CSR_TCFG:      tcfg_d      = wmerge(tcfg_q, csr_wvalue, csr_wmask, FULL_WMASK);
        default: ;
      endcase
    end
    // Sampled interrupt lines track the pins every cycle; timer set beats TICLR clear.
    estat_d[9:2]      = hw_int_in;
    estat_d[ESTAT_IPI] = ipi_int_in;
    if (ticlr_clr)    estat_d[ESTAT_TI] = 1'b0;
    if (timer_expire) estat_d[ESTAT_TI] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q <= CRMD_RESET; prmd_q <= '0; ecfg_q <= '0; estat_q <= '0;
      era_q <= '0; badv_q <= '0; eentry_q <= '0; tlbrentry_q <= '0;
      tid_q <= TID_RESET; tcfg_q <= '0; save_q <= '0;
    end else begin
      crmd_q <= crmd_d; prmd_q <= prmd_d; ecfg_q <= ecfg_d; estat_q <= estat_d;
      era_q <= era_d; badv_q <= badv_d; eentry_q <= eentry_d; tlbrentry_q <= tlbrentry_d;
      tid_q <= tid_d; tcfg_q <= tcfg_d; save_q <= save_d;
    end
  end

  csr_timer u_timer (
    .clk           (clk),
    .resetn        (resetn),
    .tcfg_we       (tcfg_we),
    .tcfg_en       (tcfg_d[TCFG_EN]),
    .tcfg_periodic (tcfg_d[TCFG_PERIODIC]),
    .tcfg_initval  (tcfg_d[31:2]),
    .tval          (tval),
    .expire        (timer_expire)
  );

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CSR_CRMD:      csr_rvalue = crmd_q;
      CSR_PRMD:      csr_rvalue = prmd_q;
      CSR_ECFG:      csr_rvalue = ecfg_q;
      CSR_ESTAT:     csr_rvalue = estat_q;
      CSR_ERA:       csr_rvalue = era_q;
      CSR_BADV:      csr_rvalue = badv_q;
      CSR_EENTRY:    csr_rvalue = eentry_q;
      CSR_TLBRENTRY: csr_rvalue = tlbrentry_q;
      CSR_SAVE0:     csr_rvalue = save_q[0];
      CSR_SAVE1:     csr_rvalue = save_q[1];
      CSR_SAVE2:     csr_rvalue = save_q[2];
      CSR_SAVE3:     csr_rvalue = save_q[3];
      CSR_TID:       csr_rvalue = tid_q;
      CSR_TCFG:      csr_rvalue = tcfg_q;
      CSR_TVAL:      csr_rvalue = tval;
      default:       csr_rvalue = 32'h0;
    endcase
  end

  assign has_int    = crmd_q[CRMD_IE] && |(estat_q[12:0] & ecfg_q[12:0]);
  assign ex_entry   = (wb_ecode == ECODE_TLBR) ? tlbrentry_q : eentry_q;
  assign ertn_entry = era_q;

endmodule
